// File: rtl/route_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : route_prbs_checker
// Purpose  : PRBS7 (x^7+x^6+1) checker for a routed net under test. It
//            synchronises a local 7-bit predictor to the incoming stream
//            (SEARCH), confirms the lock over LOCK_COUNT consecutive matches
//            (VERIFY), then counts checked bits and mismatches (LOCKED).
//            It drops back to SEARCH after UNLOCK_ERRS consecutive misses.
// Ports    : clk        - sole clock, rising edge
//            rst_n      - asynchronous active-low reset
//            en         - checker enable; low forces SEARCH
//            rx_valid   - qualifies rx_bit this cycle
//            rx_bit     - sampled bit from the net under test
//            clr        - synchronous clear of err_cnt / bit_cnt
//            state      - 0=SEARCH, 1=VERIFY, 2=LOCKED
//            locked     - high while in LOCKED
//            err_pulse  - one-cycle strobe per mismatch counted in LOCKED
//            err_cnt    - saturating mismatch count
//            bit_cnt    - saturating count of bits checked in LOCKED
// Revision : 1.0 - initial release
// ============================================================================
module route_prbs_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx_valid,
    input  logic                 rx_bit,
    input  logic                 clr,
    output logic [1:0]           state,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e               state_q;
    logic [6:0]           s_q;
    logic [2:0]           fill_q;
    logic [7:0]           match_q;
    logic [3:0]           miss_q;
    logic                 locked_q;
    logic                 err_pulse_q;
    logic [ERR_WIDTH-1:0] err_cnt_q;
    logic [CNT_WIDTH-1:0] bit_cnt_q;

    // Combinational helpers for the current valid bit.
    logic       pred_d;
    logic       mismatch_d;
    logic [6:0] s_fill_d;   // register after shifting in the received bit
    logic [6:0] s_pred_d;   // register after shifting in the prediction
    logic       chk_lock_d; // a valid bit is being checked in LOCKED

    assign pred_d     = s_q[6] ^ s_q[5];
    assign mismatch_d = rx_bit ^ pred_d;
    assign s_fill_d   = {s_q[5:0], rx_bit};
    assign s_pred_d   = {s_q[5:0], pred_d};
    assign chk_lock_d = en && rx_valid && (state_q == ST_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            s_q         <= 7'd0;
            fill_q      <= 3'd0;
            match_q     <= 8'd0;
            miss_q      <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;

            if (!en) begin
                state_q  <= ST_SEARCH;
                locked_q <= 1'b0;
                fill_q   <= 3'd0;
                match_q  <= 8'd0;
                miss_q   <= 4'd0;
            end else if (rx_valid) begin
                case (state_q)
                    ST_SEARCH: begin
                        s_q <= s_fill_d;
                        if (fill_q == 3'd6) begin
                            fill_q <= 3'd0;
                            // An all-zero seed is the LFSR lock-up state and
                            // can never produce a PRBS, so keep searching.
                            if (s_fill_d != 7'd0) begin
                                state_q <= ST_VERIFY;
                                match_q <= 8'd0;
                            end
                        end else begin
                            fill_q <= fill_q + 3'd1;
                        end
                    end

                    ST_VERIFY: begin
                        if (!mismatch_d) begin
                            s_q <= s_pred_d;
                            if (match_q + 8'd1 == 8'(LOCK_COUNT)) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                match_q  <= 8'd0;
                                miss_q   <= 4'd0;
                            end else begin
                                match_q <= match_q + 8'd1;
                            end
                        end else begin
                            state_q <= ST_SEARCH;
                            fill_q  <= 3'd0;
                            match_q <= 8'd0;
                        end
                    end

                    ST_LOCKED: begin
                        // Free-run on the prediction so a corrupted bit does
                        // not poison the reference sequence.
                        s_q <= s_pred_d;
                        if (mismatch_d) begin
                            err_pulse_q <= 1'b1;
                            if (miss_q + 4'd1 == 4'(UNLOCK_ERRS)) begin
                                state_q  <= ST_SEARCH;
                                locked_q <= 1'b0;
                                miss_q   <= 4'd0;
                                fill_q   <= 3'd0;
                            end else begin
                                miss_q <= miss_q + 4'd1;
                            end
                        end else begin
                            miss_q <= 4'd0;
                        end
                    end

                    default: begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        fill_q   <= 3'd0;
                        match_q  <= 8'd0;
                        miss_q   <= 4'd0;
                    end
                endcase
            end

            // Clear wins over a coincident increment.
            if (clr) begin
                err_cnt_q <= '0;
                bit_cnt_q <= '0;
            end else if (chk_lock_d) begin
                if (bit_cnt_q != '1) begin
                    bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
                end
                if (mismatch_d && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + ERR_WIDTH'(1);
                end
            end
        end
    end

    assign state     = state_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_route_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_route_prbs_checker
// Purpose  : Self-checking bench for route_prbs_checker. Two instances share
//            stimulus: one with default widths, one with narrow counters so
//            saturation is reachable. Outputs are compared every cycle with
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_route_prbs_checker;

    localparam int LOCK_COUNT  = 16;
    localparam int UNLOCK_ERRS = 4;

    logic        clk = 1'b0;
    logic        rst_n, en, rx_valid, rx_bit, clr;
    logic [1:0]  a_state, b_state;
    logic        a_locked, b_locked, a_pulse, b_pulse;
    logic [15:0] a_err;
    logic [31:0] a_bits;
    logic [3:0]  b_err;
    logic [7:0]  b_bits;

    route_prbs_checker #(
        .LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(UNLOCK_ERRS),
        .ERR_WIDTH(16), .CNT_WIDTH(32)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .rx_valid(rx_valid),
        .rx_bit(rx_bit), .clr(clr), .state(a_state), .locked(a_locked),
        .err_pulse(a_pulse), .err_cnt(a_err), .bit_cnt(a_bits)
    );

    route_prbs_checker #(
        .LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(UNLOCK_ERRS),
        .ERR_WIDTH(4), .CNT_WIDTH(8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .rx_valid(rx_valid),
        .rx_bit(rx_bit), .clr(clr), .state(b_state), .locked(b_locked),
        .err_pulse(b_pulse), .err_cnt(b_err), .bit_cnt(b_bits)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 collecting a seed, 1 confirming, 2 locked.
    // m_hist holds the 7 most recent reference bits, oldest first.
    int      m_mode;
    bit      m_hist[$];
    int      m_match, m_miss;
    bit      m_pulse;
    longint  m_err, m_bits;   // true counts since last clear/reset

    function automatic longint smin(input longint a, input longint lim);
        return (a < lim) ? a : lim;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hist.delete(); m_match = 0; m_miss = 0;
        m_pulse = 0; m_err = 0; m_bits = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input bit b, input bit c);
        bit p, any1;
        m_pulse = 0;
        if (!e) begin
            m_mode = 0; m_hist.delete(); m_match = 0; m_miss = 0;
        end else if (v) begin
            case (m_mode)
                0: begin
                    m_hist.push_back(b);
                    if (m_hist.size() == 7) begin
                        any1 = 0;
                        foreach (m_hist[k]) any1 |= m_hist[k];
                        if (any1) begin m_mode = 1; m_match = 0; end
                        else m_hist.delete();
                    end
                end
                1: begin
                    p = m_hist[0] ^ m_hist[1];
                    if (b == p) begin
                        void'(m_hist.pop_front()); m_hist.push_back(p);
                        m_match++;
                        if (m_match == LOCK_COUNT) begin m_mode = 2; m_miss = 0; end
                    end else begin
                        m_mode = 0; m_hist.delete(); m_match = 0;
                    end
                end
                default: begin
                    p = m_hist[0] ^ m_hist[1];
                    void'(m_hist.pop_front()); m_hist.push_back(p);
                    m_bits++;
                    if (b != p) begin
                        m_err++; m_pulse = 1; m_miss++;
                        if (m_miss == UNLOCK_ERRS) begin
                            m_mode = 0; m_hist.delete(); m_miss = 0; m_match = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            endcase
        end
        if (c) begin m_err = 0; m_bits = 0; end
    endtask

    task automatic check_all();
        chk("state_a",  32'(a_state),  32'(m_mode));
        chk("state_b",  32'(b_state),  32'(m_mode));
        chk("locked_a", 32'(a_locked), 32'(m_mode == 2));
        chk("pulse_a",  32'(a_pulse),  32'(m_pulse));
        chk("pulse_b",  32'(b_pulse),  32'(m_pulse));
        chk("errcnt_a", 32'(a_err),    32'(smin(m_err, 65535)));
        chk("errcnt_b", 32'(b_err),    32'(smin(m_err, 15)));
        chk("bitcnt_a", a_bits,        32'(smin(m_bits, 64'hFFFF_FFFF)));
        chk("bitcnt_b", 32'(b_bits),   32'(smin(m_bits, 255)));
    endtask

    // ---------------- PRBS7 source ----------------
    logic [6:0] g;
    task automatic prbs_bit(output bit b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    // Called #1 after a rising edge; applies inputs for one edge and checks.
    task automatic cycle(input bit e, input bit v, input bit b, input bit c);
        en = e; rx_valid = v; rx_bit = b; clr = c;
        model_step(e, v, b, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"},  32'(a_state),  32'd0);
        chk({tag, "_locked"}, 32'(a_locked), 32'd0);
        chk({tag, "_pulse"},  32'(a_pulse),  32'd0);
        chk({tag, "_err"},    32'(a_err),    32'd0);
        chk({tag, "_bits"},   a_bits,        32'd0);
        chk({tag, "_err_b"},  32'(b_err),    32'd0);
    endtask

    // Asynchronous reset mid-cycle, released away from the clock edge.
    task automatic do_reset(input string tag);
        en = 0; rx_valid = 0; rx_bit = 0; clr = 0;
        #1 rst_n = 0;
        #1 check_reset_vals(tag);
        model_reset();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1 check_all();
    endtask

    task automatic relock();
        bit b;
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 7 + LOCK_COUNT; i++) begin
            prbs_bit(b);
            cycle(1, 1, b, 0);
        end
        chk("relock", 32'(a_locked), 32'd1);
    endtask

    initial begin
        bit b, seen_lock;
        int nvalid;
        rst_n = 0; en = 0; rx_valid = 0; rx_bit = 0; clr = 0;
        g = 7'h7F;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Clean stream: VERIFY after bit 7, LOCKED after bit 23.
        for (int i = 1; i <= 40; i++) begin
            prbs_bit(b);
            cycle(1, 1, b, 0);
            if (i == 7)  chk("verify_at_7", 32'(a_state), 32'd1);
            if (i == 22) chk("unlocked_at_22", 32'(a_locked), 32'd0);
            if (i == 23) chk("locked_at_23", 32'(a_locked), 32'd1);
        end
        chk("bitcnt_after_40", a_bits, 32'd17);
        chk("errcnt_clean", 32'(a_err), 32'd0);

        // Single inverted bit.
        prbs_bit(b);
        cycle(1, 1, ~b, 0);
        chk("single_pulse", 32'(a_pulse), 32'd1);
        chk("single_err", 32'(a_err), 32'd1);
        chk("single_locked", 32'(a_locked), 32'd1);
        prbs_bit(b);
        cycle(1, 1, b, 0);
        chk("single_pulse_off", 32'(a_pulse), 32'd0);
        for (int i = 0; i < 8; i++) begin prbs_bit(b); cycle(1, 1, b, 0); end

        // Clear, then four consecutive inversions force SEARCH.
        prbs_bit(b);
        cycle(1, 1, b, 1);
        for (int i = 1; i <= 4; i++) begin
            prbs_bit(b);
            cycle(1, 1, ~b, 0);
            if (i == 3) chk("still_locked_3", 32'(a_locked), 32'd1);
        end
        chk("unlock_state", 32'(a_state), 32'd0);
        chk("unlock_err", 32'(a_err), 32'd4);
        for (int i = 1; i <= 23; i++) begin prbs_bit(b); cycle(1, 1, b, 0); end
        chk("relock_23", 32'(a_locked), 32'd1);

        // Constant 0 never leaves SEARCH; constant 1 never locks.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cycle(1, 1, 0, 0);
        chk("const0_search", 32'(a_state), 32'd0);
        seen_lock = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1, 1, 1, 0);
            seen_lock |= a_locked;
        end
        chk("const1_never_locked", 32'(seen_lock), 32'd0);

        // Alternating error/match: narrow err_cnt saturates at 15.
        relock();
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            prbs_bit(b);
            cycle(1, 1, (i % 2 == 0) ? ~b : b, 0);
        end
        chk("sat_err_b", 32'(b_err), 32'd15);
        chk("alt_err_a", 32'(a_err), 32'd20);
        chk("alt_locked", 32'(a_locked), 32'd1);
        prbs_bit(b);
        cycle(1, 1, ~b, 1);
        chk("clr_vs_err_a", 32'(a_err), 32'd0);
        chk("clr_vs_err_b", 32'(b_err), 32'd0);
        chk("clr_keeps_pulse", 32'(a_pulse), 32'd1);
        for (int i = 0; i < 300; i++) begin prbs_bit(b); cycle(1, 1, b, 0); end
        chk("sat_bits_b", 32'(b_bits), 32'd255);

        // Gapped valid: one valid bit in three cycles.
        cycle(0, 0, 0, 0);
        nvalid = 0;
        for (int i = 0; i < 3 * 23; i++) begin
            if (i % 3 == 0) begin
                prbs_bit(b);
                nvalid++;
                cycle(1, 1, b, 0);
                if (nvalid == 22) chk("gap_unlocked_22", 32'(a_locked), 32'd0);
                if (nvalid == 23) chk("gap_locked_23", 32'(a_locked), 32'd1);
            end else begin
                cycle(1, 0, $urandom_range(0, 1), 0);
            end
        end

        // Reset while locked.
        for (int i = 0; i < 5; i++) begin prbs_bit(b); cycle(1, 1, b, 0); end
        do_reset("rst_locked");

        // Randomised traffic with error injection, enable drops and clears.
        for (int i = 0; i < 3000; i++) begin
            bit e, v, c, x;
            e = ($urandom_range(0, 59) != 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 149) == 0);
            x = ($urandom_range(0, 19) == 0);
            b = $urandom_range(0, 1);
            if (v) prbs_bit(b);
            cycle(e, v, b ^ x, c);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/route_prbs_checker.md
ROUTE_PRBS_CHECKER -- requirements
Module: route_prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 16, meaning consecutive matching bits in VERIFY required to enter LOCKED (range 1..255).
REQ-002 SHALL have parameter UNLOCK_ERRS, default 4, meaning consecutive mismatches in LOCKED that force return to SEARCH (range 1..15).
REQ-003 SHALL have parameter ERR_WIDTH, default 16, meaning width of err_cnt.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, meaning width of bit_cnt.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  checker enable; low forces SEARCH.
REQ-008 rx_valid  input  1  qualifies rx_bit for the current cycle.
REQ-009 rx_bit  input  1  bit sampled from the routed net under test, driven by a PRBS7 source.
REQ-010 clr  input  1  synchronous clear of err_cnt and bit_cnt.
REQ-011 state  output  2  current state: 0=SEARCH, 1=VERIFY, 2=LOCKED (3 unused).
REQ-012 locked  output  1  high while state==LOCKED.
REQ-013 err_pulse  output  1  one-cycle strobe per mismatch counted in LOCKED.
REQ-014 err_cnt  output  ERR_WIDTH  saturating mismatch count.
REQ-015 bit_cnt  output  CNT_WIDTH  saturating count of bits checked in LOCKED.

Function
REQ-016 Polynomial SHALL be x^7+x^6+1: with 7-bit shift register s (s[6] oldest), predicted bit p = s[6]^s[5]; on each valid checked bit s <= {s[5:0], p}.
REQ-017 Only cycles with en=1 and rx_valid=1 ("valid bit") SHALL advance any state, shift register, or counter; all else holds.
REQ-018 SEARCH: each valid bit shifts in as s <= {s[5:0], rx_bit}; fill counter increments; on the 7th bit move to VERIFY, unless the resulting s==0, then stay in SEARCH with fill counter reset to 0.
REQ-019 VERIFY: each valid bit compared with p; match increments match counter and advances s; match counter reaching LOCK_COUNT enters LOCKED; any mismatch returns to SEARCH with fill and match counters 0.
REQ-020 LOCKED: each valid bit compared with p; s advances on prediction (not rx_bit) regardless of result; bit_cnt increments by 1.
REQ-021 LOCKED mismatch: err_cnt increments, err_pulse asserts next cycle for exactly one cycle, miss counter increments; match clears miss counter.
REQ-022 Miss counter reaching UNLOCK_ERRS SHALL return state to SEARCH; that final mismatch is still counted in err_cnt.
REQ-023 state/locked SHALL update in the cycle after the valid bit causing the transition (1-cycle latency); err_pulse likewise registered.
REQ-024 err_cnt and bit_cnt SHALL saturate at all-ones and not wrap.
REQ-025 clr=1 SHALL zero err_cnt and bit_cnt next cycle, taking priority over a coincident increment; does not alter state, s, or err_pulse.
REQ-026 en=0 SHALL force SEARCH next cycle with fill, match, miss counters 0; err_cnt and bit_cnt hold.
REQ-027 Counters SHALL not change in SEARCH or VERIFY.

Reset
REQ-028 rst_n low SHALL immediately clear: state=SEARCH, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0, s=0, fill/match/miss counters=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abort it with no partial update; release is synchronous to next clk edge, first valid bit after release treated as SEARCH bit 1.

Verification
REQ-030 Clean PRBS7 stream seed 7'b1111111, rx_valid=1 continuously -> state VERIFY after bit 7, locked=1 after bit 23 (7+16), err_cnt=0, bit_cnt increments each cycle thereafter.
REQ-031 Locked, single rx_bit inverted -> err_pulse high one cycle, err_cnt=1, locked stays 1, next clean bits keep checking (miss counter back to 0).
REQ-032 Locked, 4 consecutive inverted bits -> err_cnt=4, state=SEARCH cycle after 4th, relock after further 23 clean bits.
REQ-033 Constant rx_bit=0 -> never leaves SEARCH; constant 1 -> VERIFY then back to SEARCH on first mismatch, never LOCKED.
REQ-034 ERR_WIDTH=4, continuous alternating error/match in LOCKED -> err_cnt holds at 15; clr concurrent with a mismatch -> err_cnt=0.
REQ-035 rx_valid gapped (1 of 3 cycles) -> lock after 23 valid bits; rst_n pulse while LOCKED -> all outputs to reset values asynchronously.
